xorshift_rng_stream: RTL
========================

# xorshift_rng_stream

Parametrised streaming xorshift PRNG, successor to the single-shot 32-bit generator in the AXI PRNG IP. Supports 32- or 64-bit state and an on-demand or free-running generation mode. Range mapping is pipelined and multiply-based, and results feed a ready/valid output FIFO. Sits between the AXI-Lite register slave (seed, range, mode, control) and stream consumers such as DMA or test-pattern sinks.

## Interface
Parameters:
- WIDTH, 32 — state/output width; legal values 32 or 64.
- DEPTH, 8 — output FIFO depth; power of two, ≥2.
- DEFAULT_SEED, 42 — reset seed; also substituted whenever a zero seed is written.
- DEFAULT_LOW, 0 — reset range low bound (inclusive).
- DEFAULT_HIGH, 100 — reset range high bound (exclusive).

Ports:
- clk  in  1  — single clock; all logic on its rising edge.
- aresetn  in  1  — asynchronous, active-low reset.
- prng_reset  in  1  — synchronous soft reset, same effect as aresetn.
- enable  in  1  — global generation enable.
- mode  in  1  — 0 = on-demand, 1 = free-run.
- gen_req  in  1  — on-demand step request, one value per cycle high.
- update_seed  in  1  — load new_seed.
- new_seed  in  WIDTH  — seed value.
- update_range  in  1  — load new_low/new_high.
- new_low, new_high  in  WIDTH  — range bounds, [low, high).
- out_valid  out  1  — FIFO head valid.
- out_ready  in  1  — consumer accept.
- out_raw  out  WIDTH  — raw state value at FIFO head.
- out_range  out  WIDTH  — mapped value at FIFO head.
- fifo_count  out  $clog2(DEPTH)+1  — entries stored.
- req_dropped  out  1  — sticky; set when a gen_req is refused.

## Operation
- **Step functions:**
  - WIDTH=32: x^=x<<13; x^=x>>17; x^=x<<5.
  - WIDTH=64: x^=x<<13; x^=x>>7; x^=x<<17.
- **Reset state** (aresetn low or prng_reset):
  - state=DEFAULT_SEED, low=DEFAULT_LOW, high=DEFAULT_HIGH.
  - Pipeline and FIFO flushed.
  - out_valid=0, out_raw=0, out_range=0, fifo_count=0, req_dropped=0.
- **Priority each cycle:** prng_reset > update_seed > generation step.
- **update_seed:** state ← (new_seed==0 ? DEFAULT_SEED : new_seed). No step that cycle; a coincident gen_req is refused.
- **update_range:**
  - Stores bounds; if new_high ≤ new_low, stores high = new_low+1.
  - Applies to values entering the mapping stage on the following edge. In-flight values keep the old range.
- **Credit:** a step is allowed only if fifo_count + in-flight (mapping stage) < DEPTH.
- **Step conditions:**
  - Free-run: step every cycle with enable=1 and credit.
  - On-demand: step when enable=1, gen_req=1, and credit.
  - Refused gen_req (no credit, enable=0, or seed update): sets req_dropped.
- **Mapping stage:**
  - span = high−low (WIDTH bits).
  - out_range = low + ((raw × span) >> WIDTH), using a 2×WIDTH-bit product.
  - Result always lies in [low, high−1].
- **FIFO:** show-ahead; pop on out_valid && out_ready. Push and pop in the same cycle leave the count unchanged.

## Timing
- **Step accepted at edge E0:** state updates at E0.
  - Mapping stage registers {raw, mapped} at E1.
  - FIFO write at E2; out_valid is high after E2 if the FIFO was empty.
  - Latency: 2 cycles from the accepting edge to out_valid.
- **Throughput:** one value per cycle in free-run with out_ready held high.
- **Full FIFO:** no further steps until a pop frees credit. State is not advanced, so no values are lost in free-run.
- **Backpressure:** while out_ready=0, out_raw and out_range hold stable.
- **prng_reset mid-stream:** the flush takes effect at that edge; out_valid=0 the following cycle.
- **aresetn:** asserted asynchronously at any time; outputs go to reset values immediately.

## Test plan
- WIDTH=32, seed 42, range [0,100), on-demand, one gen_req → two cycles later out_valid=1, out_raw=0x00AD4528, out_range=0.
- Write seed 0, then one gen_req → same head as the previous test: out_raw=0x00AD4528.
- Range [50,150), 20 free-run values → every out_range in 50..149, consecutive raw values all different.
- Range [100,50) written → every value 100; range [42,43) written → every value 42.
- Free-run with out_ready=0 → fifo_count saturates at DEPTH, outputs stable. Then raise out_ready → the drained sequence is gap-free versus a reference model, with no repeated or skipped states.
- On-demand with FIFO full, gen_req pulse → req_dropped=1, fifo_count unchanged. Then prng_reset → all outputs 0, and the next value is again 0x00AD4528.

Source files
------------

// File: rtl/xorshift_rng_stream.sv
// Streaming xorshift PRNG with pipelined range mapping and output FIFO.
// Ports:
//   clk, aresetn      clock, async active-low reset
//   prng_reset        sync soft reset (same effect as aresetn)
//   enable, mode      generation enable; 0 = on-demand, 1 = free-run
//   gen_req           on-demand step request
//   update_seed       load new_seed (zero maps to DEFAULT_SEED)
//   update_range      load [new_low, new_high)
//   out_*             show-ahead ready/valid head: raw and mapped value
//   fifo_count        entries stored
//   req_dropped       sticky flag for refused gen_req
module xorshift_rng_stream #(
    parameter int          WIDTH        = 32,
    parameter int          DEPTH        = 8,
    parameter logic [63:0] DEFAULT_SEED = 64'd42,
    parameter logic [63:0] DEFAULT_LOW  = 64'd0,
    parameter logic [63:0] DEFAULT_HIGH = 64'd100
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     prng_reset,
    input  logic                     enable,
    input  logic                     mode,
    input  logic                     gen_req,
    input  logic                     update_seed,
    input  logic [WIDTH-1:0]         new_seed,
    input  logic                     update_range,
    input  logic [WIDTH-1:0]         new_low,
    input  logic [WIDTH-1:0]         new_high,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_raw,
    output logic [WIDTH-1:0]         out_range,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     req_dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [WIDTH-1:0] SEED_C = WIDTH'(DEFAULT_SEED);
    localparam logic [WIDTH-1:0] LOW_C  = WIDTH'(DEFAULT_LOW);
    localparam logic [WIDTH-1:0] HIGH_C = WIDTH'(DEFAULT_HIGH);

    function automatic logic [WIDTH-1:0] xs_next(
        input logic [WIDTH-1:0] x
    );
        logic [WIDTH-1:0] y;
        y = x ^ (x << 13);
        if (WIDTH == 32) begin
            y = y ^ (y >> 17);
            y = y ^ (y << 5);
        end else begin
            y = y ^ (y >> 7);
            y = y ^ (y << 17);
        end
        return y;
    endfunction

    logic [WIDTH-1:0]   state;
    logic [WIDTH-1:0]   low;
    logic [WIDTH-1:0]   high;
    logic [WIDTH-1:0]   span;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mapped;

    logic               step;
    logic               step_q;
    logic               map_valid;
    logic [WIDTH-1:0]   map_raw;
    logic [WIDTH-1:0]   map_rng;
    logic [CW:0]        in_use;
    logic               credit;

    logic [WIDTH-1:0]   mem_raw [DEPTH];
    logic [WIDTH-1:0]   mem_rng [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               push;
    logic               pop;

    // Both the freshly stepped state and the mapping register hold a
    // value already promised a FIFO slot, so both count against credit.
    assign in_use = {1'b0, count}
                  + (CW+1)'(step_q)
                  + (CW+1)'(map_valid);
    assign credit = in_use < (CW+1)'(DEPTH);

    assign step = enable && credit && !update_seed
               && (mode || gen_req);

    assign span   = high - low;
    assign prod   = {{WIDTH{1'b0}}, state}
                  * {{WIDTH{1'b0}}, span};
    assign mapped = low + prod[2*WIDTH-1:WIDTH];

    assign push = map_valid;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= SEED_C;
            low         <= LOW_C;
            high        <= HIGH_C;
            step_q      <= 1'b0;
            map_valid   <= 1'b0;
            map_raw     <= '0;
            map_rng     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_dropped <= 1'b0;
        end else if (prng_reset) begin
            state       <= SEED_C;
            low         <= LOW_C;
            high        <= HIGH_C;
            step_q      <= 1'b0;
            map_valid   <= 1'b0;
            map_raw     <= '0;
            map_rng     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_dropped <= 1'b0;
        end else begin
            if (update_seed) begin
                state <= (new_seed == '0) ? SEED_C : new_seed;
            end else if (step) begin
                state <= xs_next(state);
            end

            // An empty or inverted range collapses to the single value low.
            if (update_range) begin
                low  <= new_low;
                high <= (new_high <= new_low)
                      ? new_low + WIDTH'(1)
                      : new_high;
            end

            step_q    <= step;
            map_valid <= step_q;
            if (step_q) begin
                map_raw <= state;
                map_rng <= mapped;
            end

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (!mode && gen_req && !step) begin
                req_dropped <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_raw[wr_ptr] <= map_raw;
            mem_rng[wr_ptr] <= map_rng;
        end
    end

    assign out_valid  = (count != '0);
    assign out_raw    = out_valid ? mem_raw[rd_ptr] : '0;
    assign out_range  = out_valid ? mem_rng[rd_ptr] : '0;
    assign fifo_count = count;

endmodule
